// File: rtl/dac_table_dbg_pkg.sv
// Purpose: shared FSM state encoding and report record layout for the deadlock reporter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dac_table_dbg_pkg;

    localparam int MAX_MON = 16;
    localparam int ID_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DECLARED = 2'd2,
        REPORTED = 2'd3
    } dl_state_t;

    // Sized for the largest monitor count; the top slices the mask down to NUM_MON.
    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [MAX_MON-1:0] mask;
    } report_rec_t;

endpackage

// File: rtl/dac_table_prio_enc.sv
// Purpose: lowest-set-bit encoder over the monitor block flags.
// Latency: combinational.
// Backpressure: none.
module dac_table_prio_enc #(
    parameter int NUM_MON = 4
) (
    input  logic [NUM_MON-1:0] vec,
    output logic [3:0]         idx,
    output logic               any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/dac_table_deadlock_reporter.sv
// Purpose: declare deadlock after THRESHOLD consecutive blocked cycles and emit one report record.
// Latency: deadlock/report_valid rise the cycle after the THRESHOLD-th blocked cycle.
// Backpressure: report held (id/mask stable, cycles counting) until report_ready; clear overrides.
module dac_table_deadlock_reporter
    import dac_table_dbg_pkg::*;
#(
    parameter int NUM_MON   = 4,
    parameter int THRESHOLD = 1000,
    parameter int CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               clear,
    output logic               deadlock,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [3:0]         report_id,
    output logic [NUM_MON-1:0] report_mask,
    output logic [CNT_W-1:0]   report_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESHOLD - 1);

    dl_state_t        state_q;
    dl_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       first_id_q;
    report_rec_t      rec_q;
    logic [3:0]       enc_idx;
    logic             blocked;
    logic             declare_now;
    logic             unused_rec_bits;

    dac_table_prio_enc #(.NUM_MON(NUM_MON)) u_prio_enc (
        .vec (mon_block),
        .idx (enc_idx),
        .any (blocked)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; clear overrides every transition, including acceptance.
    always_comb begin
        state_d     = state_q;
        declare_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (blocked) state_d = WATCH;
            end
            WATCH: begin
                if (!blocked) begin
                    state_d = IDLE;
                end else if (cnt_q == THR_M1) begin
                    state_d     = DECLARED;
                    declare_now = 1'b1;
                end
            end
            DECLARED: begin
                if (report_ready) state_d = REPORTED;
            end
            REPORTED: begin
                state_d = REPORTED;
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d     = IDLE;
            declare_now = 1'b0;
        end
        deadlock     = (state_q == DECLARED) || (state_q == REPORTED);
        report_valid = (state_q == DECLARED);
    end

    // Run length while watching, then saturating blocked-cycle count until acceptance freezes it.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE:     cnt_q <= blocked ? CNT_W'(1) : '0;
                WATCH:    cnt_q <= blocked ? cnt_q + CNT_W'(1) : '0;
                DECLARED: begin
                    if (blocked && !report_ready && cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default:  cnt_q <= cnt_q;
            endcase
        end
    end

    // The culprit is whoever blocked first, so latch it at the start of the run.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            first_id_q <= '0;
        end else if (state_q == IDLE && blocked) begin
            first_id_q <= enc_idx;
        end
    end

    // Snapshot the record on the declaring cycle; it stays put until clear or reset.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            rec_q <= '0;
        end else if (declare_now) begin
            rec_q <= '{id: first_id_q, mask: MAX_MON'(mon_block)};
        end
    end

    assign report_id       = rec_q.id;
    assign report_mask     = rec_q.mask[NUM_MON-1:0];
    assign report_cycles   = deadlock ? cnt_q : '0;
    assign unused_rec_bits = ^rec_q.mask;

endmodule

// File: tb/tb_dac_table_deadlock_reporter.sv
// Purpose: randomized and directed scoreboard bench for the deadlock reporter.
// Latency: expects deadlock at run start + THRESHOLD cycles, drop one cycle after clear/reset.
// Backpressure: report_ready driven low for random stretches to exercise holding.
module tb_dac_table_deadlock_reporter;

    localparam int THR     = 1000;
    localparam int CNT_MAX = 65535;

    logic        clock = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  mon_block;
    logic        report_ready;
    logic        deadlock;
    logic        report_valid;
    logic [3:0]  report_id;
    logic [3:0]  report_mask;
    logic [15:0] report_cycles;

    logic [3:0]  s_mon_block;
    logic        s_report_ready;
    logic        s_deadlock;
    logic        s_report_valid;
    logic [3:0]  s_report_id;
    logic [3:0]  s_report_mask;
    logic [7:0]  s_report_cycles;

    dac_table_deadlock_reporter #(.NUM_MON(4), .THRESHOLD(THR), .CNT_W(16)) u_dut (
        .clock         (clock),
        .reset         (reset),
        .mon_block     (mon_block),
        .clear         (clear),
        .deadlock      (deadlock),
        .report_valid  (report_valid),
        .report_ready  (report_ready),
        .report_id     (report_id),
        .report_mask   (report_mask),
        .report_cycles (report_cycles)
    );

    dac_table_deadlock_reporter #(.NUM_MON(4), .THRESHOLD(200), .CNT_W(8)) u_sat (
        .clock         (clock),
        .reset         (reset),
        .mon_block     (s_mon_block),
        .clear         (clear),
        .deadlock      (s_deadlock),
        .report_valid  (s_report_valid),
        .report_ready  (s_report_ready),
        .report_id     (s_report_id),
        .report_mask   (s_report_mask),
        .report_cycles (s_report_cycles)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit lvl;
    } dl_ev_t;

    typedef struct {
        logic [3:0] id;
        logic [3:0] mask;
        int         cycles;
    } rep_t;

    dl_ev_t dl_q[$];
    rep_t   rep_q[$];
    int     checks   = 0;
    int     failures = 0;
    bit     mon_en   = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lowest_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: deadlock edges, report handshakes and hold stability, all at the falling edge.
    bit         prev_dl   = 1'b0;
    bit         prev_wait = 1'b0;
    logic [3:0] prev_id;
    logic [3:0] prev_mask;

    always @(negedge clock) begin
        if (mon_en) begin
            if (deadlock != prev_dl) begin
                if (dl_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL deadlock_unexpected_edge actual=%0d required=%0d cyc=%0d", deadlock, prev_dl, cyc);
                end else begin
                    dl_ev_t ev;
                    ev = dl_q.pop_front();
                    chk("deadlock_edge_cycle", cyc, ev.cyc);
                    chk("deadlock_edge_level", deadlock, ev.lvl);
                end
            end
            if (report_valid && report_ready && !clear && !reset) begin
                if (rep_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL report_unexpected actual=handshake required=none cyc=%0d", cyc);
                end else begin
                    rep_t r;
                    r = rep_q.pop_front();
                    chk("report_id", report_id, r.id);
                    chk("report_mask", report_mask, r.mask);
                    chk("report_cycles", report_cycles, r.cycles);
                end
            end
            if (prev_wait && report_valid) begin
                chk("hold_id_stable", report_id, prev_id);
                chk("hold_mask_stable", report_mask, prev_mask);
            end
        end
        prev_dl   = deadlock;
        prev_wait = report_valid && !report_ready && !clear && !reset;
        prev_id   = report_id;
        prev_mask = report_mask;
    end

    // One blocked run: v1 for k cycles, then v2 up to cycle l, then idle; ready rises after cycle r.
    // mode 0: accept, linger, clear. mode 1: clear with ready on the accept cycle. mode 2: reset there.
    task automatic run_case(input logic [3:0] v1, input int k, input logic [3:0] v2,
                            input int l, input int r, input int mode);
        int   c0;
        int   ea;
        rep_t rr;
        c0 = cyc;
        ea = (r + 1 > THR + 1) ? r + 1 : THR + 1;
        dl_q.push_back('{c0 + THR, 1'b1});
        if (mode == 0) begin
            rr.id     = lowest_idx(v1);
            rr.mask   = (k >= THR) ? v1 : v2;
            rr.cycles = imin(imin(ea - 1, l), CNT_MAX);
            rep_q.push_back(rr);
        end else begin
            dl_q.push_back('{c0 + ea, 1'b0});
        end
        for (int e = 1; e <= ea; e++) begin
            mon_block    = (e <= k) ? v1 : ((e <= l) ? v2 : 4'b0000);
            report_ready = (e > r);
            if (e == ea && mode == 1) begin
                clear        = 1'b1;
                report_ready = 1'b1;
            end
            if (e == ea && mode == 2) begin
                reset        = 1'b1;
                report_ready = 1'b0;
            end
            step();
        end
        clear        = 1'b0;
        reset        = 1'b0;
        report_ready = 1'b0;
        if (mode == 2) begin
            chk("reset_mid_report_valid", report_valid, 0);
            chk("reset_mid_report_id", report_id, 0);
            chk("reset_mid_report_mask", report_mask, 0);
            chk("reset_mid_report_cycles", report_cycles, 0);
        end
        if (mode == 0) begin
            for (int i = 0; i < 20; i++) begin
                mon_block = 4'($urandom_range(0, 15));
                step();
            end
            mon_block = 4'b0000;
            clear     = 1'b1;
            dl_q.push_back('{cyc + 1, 1'b0});
            step();
            clear = 1'b0;
        end
        mon_block = 4'b0000;
        step();
        step();
    endtask

    initial begin
        reset          = 1'b1;
        clear          = 1'b0;
        mon_block      = 4'b0000;
        report_ready   = 1'b0;
        s_mon_block    = 4'b0000;
        s_report_ready = 1'b0;
        repeat (3) step();

        chk("reset_deadlock", deadlock, 0);
        chk("reset_report_valid", report_valid, 0);
        chk("reset_report_id", report_id, 0);
        chk("reset_report_mask", report_mask, 0);
        chk("reset_report_cycles", report_cycles, 0);

        reset = 1'b0;
        step();
        mon_en = 1'b1;
        step();

        // Single monitor held exactly through declaration.
        run_case(4'b0100, THR + 5, 4'b0100, THR + 5, THR, 0);
        // Run of THR-1 cycles broken by one idle cycle must not declare; the next full run does.
        mon_block = 4'b0101;
        repeat (THR - 1) step();
        mon_block = 4'b0000;
        step();
        run_case(4'b0101, THR + 3, 4'b0101, THR + 3, THR + 2, 0);
        // Culprit is the first blocker even after a lower index joins.
        run_case(4'b1000, 4, 4'b1001, THR + 10, THR + 5, 0);
        // Consumer stalls 50 cycles after declaration.
        run_case(4'b0110, THR + 60, 4'b0110, THR + 60, THR + 50, 0);
        // Blockage clears during the stall; report stays and count stops.
        run_case(4'b0011, THR + 10, 4'b0011, THR + 10, THR + 40, 0);
        // Clear and accept together.
        run_case(4'b0010, THR + 10, 4'b0010, THR + 10, THR + 3, 1);
        // Reset while the report is pending.
        run_case(4'b1100, THR + 10, 4'b1100, THR + 10, THR + 7, 2);

        // Clear mid-watch restarts the run from the next cycle.
        mon_block = 4'b0001;
        repeat (500) step();
        clear     = 1'b1;
        mon_block = 4'b1010;
        step();
        clear = 1'b0;
        run_case(4'b1010, THR + 2, 4'b1010, THR + 2, THR + 1, 0);

        for (int n = 0; n < 7; n++) begin
            logic [3:0] a;
            logic [3:0] b;
            int         k;
            int         l;
            int         r;
            int         m;
            a = 4'($urandom_range(1, 15));
            b = 4'($urandom_range(1, 15));
            k = $urandom_range(1, THR + 20);
            l = $urandom_range(THR, THR + 80);
            r = $urandom_range(0, THR + 80);
            m = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_case(a, k, b, l, r, m);
        end

        // Narrow-counter instance: declaration boundary and saturation.
        s_mon_block = 4'b0010;
        repeat (199) step();
        chk("sat_no_deadlock_at_199", s_deadlock, 0);
        step();
        chk("sat_deadlock_at_200", s_deadlock, 1);
        chk("sat_valid_at_200", s_report_valid, 1);
        repeat (100) step();
        chk("sat_cycles_saturated", s_report_cycles, 255);
        chk("sat_report_id", s_report_id, 1);
        chk("sat_report_mask", s_report_mask, 4'b0010);
        s_report_ready = 1'b1;
        step();
        s_report_ready = 1'b0;
        chk("sat_valid_dropped", s_report_valid, 0);
        chk("sat_deadlock_sticky", s_deadlock, 1);
        chk("sat_cycles_frozen", s_report_cycles, 255);
        s_mon_block = 4'b0000;
        clear       = 1'b1;
        step();
        clear = 1'b0;
        chk("sat_cleared", s_deadlock, 0);
        step();

        chk("pending_deadlock_events", dl_q.size(), 0);
        chk("pending_reports", rep_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_table_deadlock_reporter.md
DAC_TABLE_DEADLOCK_REPORTER -- requirements
Module: dac_table_deadlock_reporter

Interface
REQ-001 Parameter NUM_MON, default 4, number of per-instance deadlock monitor block inputs (1..16).
REQ-002 Parameter THRESHOLD, default 1000, consecutive blocked cycles required to declare deadlock (>=2).
REQ-003 Parameter CNT_W, default 16, width of cycle counters; THRESHOLD < 2^CNT_W.
REQ-004 clock  input  1  clock; all logic rising-edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 mon_block  input  NUM_MON  per-monitor block flags, registered outputs of the upstream deadlock monitors.
REQ-007 clear  input  1  single-cycle pulse; re-arms detector after a report.
REQ-008 deadlock  output  1  sticky deadlock flag.
REQ-009 report_valid  output  1  report record available.
REQ-010 report_ready  input  1  consumer accepts report.
REQ-011 report_id  output  4  index of first-blocking monitor.
REQ-012 report_mask  output  NUM_MON  snapshot of mon_block at declaration.
REQ-013 report_cycles  output  CNT_W  saturating count of blocked cycles at acceptance time.

Function
REQ-014 FSM states SHALL be IDLE, WATCH, DECLARED, REPORTED.
REQ-015 IDLE: any mon_block bit high SHALL go to WATCH, load run counter to 1, latch lowest set index into first_id.
REQ-016 WATCH: if mon_block==0 SHALL return to IDLE and zero run counter; else increment run counter.
REQ-017 WATCH: when run counter reaches THRESHOLD with mon_block!=0, SHALL go to DECLARED next cycle, assert deadlock, capture report_mask.
REQ-018 Detection latency: deadlock SHALL rise on the cycle after the THRESHOLD-th consecutive blocked cycle.
REQ-019 report_id SHALL be the lowest-index monitor high on the first cycle of the blocked run, not the declaration cycle.
REQ-020 DECLARED: report_valid SHALL be high; report_id/mask/cycles SHALL hold stable while report_valid && !report_ready.
REQ-021 report_cycles SHALL keep incrementing while any mon_block is high, saturating at 2^CNT_W-1, and freeze on handshake.
REQ-022 Handshake report_valid && report_ready SHALL move to REPORTED and drop report_valid next cycle.
REQ-023 REPORTED: deadlock SHALL remain high regardless of mon_block until clear.
REQ-024 clear in DECLARED or REPORTED SHALL return to IDLE, drop deadlock and report_valid, zero counters; clear in IDLE/WATCH SHALL restart in IDLE.
REQ-025 clear and report handshake in the same cycle: clear SHALL win; no REPORTED transition.
REQ-026 mon_block deasserting in DECLARED SHALL NOT withdraw the report.

Reset
REQ-027 Reset SHALL force IDLE; deadlock, report_valid 0; report_id, report_mask, report_cycles, run counter 0.
REQ-028 Reset mid-report SHALL discard the pending record without handshake.

Structure
REQ-029 State encoding enum and report-record struct SHALL live in shared package dac_table_dbg_pkg.
REQ-030 One sub-module, dac_table_prio_enc (lowest-set-bit encoder, NUM_MON in, 4-bit index out), SHALL be used.

Verification
REQ-031 mon_block=4'b0100 held 1000 cycles -> deadlock high at cycle 1001, report_id=2, mask=4'b0100.
REQ-032 mon_block high 999 cycles then 0 -> deadlock never asserts, FSM returns IDLE.
REQ-033 run starts 4'b1000, bit0 joins at cycle 5 -> report_id=3, mask=4'b1001.
REQ-034 report_ready low 50 cycles after declaration -> outputs stable; report_cycles=1050 on accept (saturation checked with CNT_W=8, THRESHOLD=200: 255).
REQ-035 clear and report_ready same cycle -> IDLE, deadlock 0 next cycle.
REQ-036 reset asserted while report_valid high -> all outputs 0 next cycle.
